// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: word address plus a req/ack handshake.
// The fetch stage is the master; the instruction memory is the slave.
interface fetch_stage_if;
   logic [31:0] IMemAddr;
   logic        IMemReq;
   logic        IMemAck;
   logic [31:0] IMemData;

   modport master (output IMemAddr, IMemReq, input IMemAck, IMemData);
   modport slave  (input IMemAddr, IMemReq, output IMemAck, IMemData);
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID pipeline register, a one-entry skid
// buffer for fetches that complete under a stall, and branch-redirect squashing.
module fetch_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_stage_if.master imem,
   input  logic          Stall,
   input  logic          PCSrc,
   input  logic [31:0]   BranchTarget,
   output logic [31:0]   InstrOut,
   output logic [31:0]   PCPlus4Out,
   output logic          ValidOut
);

   typedef enum logic [1:0] {ISSUE, HOLD, SQUASH} state_t;

   state_t      r_state, w_state;
   logic [31:0] r_pc, w_pc;
   logic [31:0] r_redir, w_redir;
   logic [31:0] r_skid_instr, w_skid_instr;
   logic [31:0] r_skid_pc4, w_skid_pc4;
   logic [31:0] r_instr, w_instr;
   logic [31:0] r_pc4, w_pc4;
   logic        r_valid, w_valid;
   logic        r_req_en;
   logic        w_req;
   logic        w_fire;
   logic [31:0] w_target;
   logic [31:0] w_pc_plus4;

   assign w_target   = BranchTarget & ~32'h3;
   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_fire     = w_req & imem.IMemAck;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ISSUE;
      else        r_state <= w_state;
   end

   // Datapath registers; r_req_en keeps the request low for the first cycle after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_en     <= 1'b0;
         r_pc         <= PC_RESET;
         r_redir      <= 32'h0;
         r_skid_instr <= 32'h0;
         r_skid_pc4   <= 32'h0;
         r_instr      <= 32'h0;
         r_pc4        <= 32'h0;
         r_valid      <= 1'b0;
      end else begin
         r_req_en     <= 1'b1;
         r_pc         <= w_pc;
         r_redir      <= w_redir;
         r_skid_instr <= w_skid_instr;
         r_skid_pc4   <= w_skid_pc4;
         r_instr      <= w_instr;
         r_pc4        <= w_pc4;
         r_valid      <= w_valid;
      end
   end

   // Next-state and next-datapath logic; redirect outranks ack and stall.
   // NOTE: every target gets a default first so no path can infer a latch.
   always_comb begin
      w_state      = r_state;
      w_pc         = r_pc;
      w_redir      = r_redir;
      w_skid_instr = r_skid_instr;
      w_skid_pc4   = r_skid_pc4;
      w_instr      = r_instr;
      w_pc4        = r_pc4;
      w_valid      = r_valid;

      if (PCSrc) begin
         w_instr      = 32'h0;
         w_pc4        = 32'h0;
         w_valid      = 1'b0;
         w_skid_instr = 32'h0;
         w_skid_pc4   = 32'h0;
      end

      unique case (r_state)
         ISSUE: begin
            if (PCSrc) begin
               // An unacked request pins the address, so the target waits in r_redir.
               if (w_req && !w_fire) begin
                  w_redir = w_target;
                  w_state = SQUASH;
               end else begin
                  w_pc = w_target;
               end
            end else if (w_fire) begin
               w_pc = w_pc_plus4;
               if (Stall) begin
                  w_skid_instr = imem.IMemData;
                  w_skid_pc4   = w_pc_plus4;
                  w_state      = HOLD;
               end else begin
                  w_instr = imem.IMemData;
                  w_pc4   = w_pc_plus4;
                  w_valid = 1'b1;
               end
            end else if (!Stall) begin
               w_instr = 32'h0;
               w_valid = 1'b0;
            end
         end
         HOLD: begin
            if (PCSrc) begin
               w_pc    = w_target;
               w_state = ISSUE;
            end else if (!Stall) begin
               w_instr = r_skid_instr;
               w_pc4   = r_skid_pc4;
               w_valid = 1'b1;
               w_state = ISSUE;
            end
         end
         SQUASH: begin
            if (PCSrc) w_redir = w_target;
            if (w_fire) begin
               w_pc    = PCSrc ? w_target : r_redir;
               w_state = ISSUE;
            end
         end
         default: w_state = ISSUE;
      endcase
   end

   // Outputs.
   always_comb begin
      w_req         = r_req_en && (r_state != HOLD);
      imem.IMemReq  = w_req;
      imem.IMemAddr = r_pc;
   end

   assign InstrOut   = r_instr;
   assign PCPlus4Out = r_pc4;
   assign ValidOut   = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a cycle table covering streaming, wait states,
// stall/skid, redirect squash and redirect-in-hold, plus a wrap/async-reset sequence.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n, rst2_n;
   logic        stall, pcsrc;
   logic [31:0] target;
   int          n_checks = 0;
   int          n_err    = 0;

   fetch_stage_if bus  ();
   fetch_stage_if bus2 ();

   logic [31:0] instr1, pc41, instr2, pc42;
   logic        valid1, valid2;

   fetch_stage #(.PC_RESET(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .imem(bus.master), .Stall(stall), .PCSrc(pcsrc),
      .BranchTarget(target), .InstrOut(instr1), .PCPlus4Out(pc41), .ValidOut(valid1));

   fetch_stage #(.PC_RESET(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .rst_n(rst2_n), .imem(bus2.master), .Stall(stall), .PCSrc(pcsrc),
      .BranchTarget(target), .InstrOut(instr2), .PCPlus4Out(pc42), .ValidOut(valid2));

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return 32'h1000_0000 + a;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        ack, stl, src;
      logic [31:0] tgt;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_instr, e_pc4;
   } vec_t;

   vec_t v[26];

   initial begin
      v[0]  = '{0,0,0,32'h0,   0,32'h0,   0,32'h0,         32'h0};
      v[1]  = '{1,0,0,32'h0,   1,32'h0,   1,mem(32'h0),    32'h4};
      v[2]  = '{1,0,0,32'h0,   1,32'h4,   1,mem(32'h4),    32'h8};
      v[3]  = '{0,0,0,32'h0,   1,32'h8,   0,32'h0,         32'h0};
      v[4]  = '{0,0,0,32'h0,   1,32'h8,   0,32'h0,         32'h0};
      v[5]  = '{1,0,0,32'h0,   1,32'h8,   1,mem(32'h8),    32'hC};
      v[6]  = '{1,0,0,32'h0,   1,32'hC,   1,mem(32'hC),    32'h10};
      v[7]  = '{1,1,0,32'h0,   1,32'h10,  1,mem(32'hC),    32'h10};
      v[8]  = '{0,1,0,32'h0,   0,32'h14,  1,mem(32'hC),    32'h10};
      v[9]  = '{0,1,0,32'h0,   0,32'h14,  1,mem(32'hC),    32'h10};
      v[10] = '{0,1,0,32'h0,   0,32'h14,  1,mem(32'hC),    32'h10};
      v[11] = '{0,0,0,32'h0,   0,32'h14,  1,mem(32'h10),   32'h14};
      v[12] = '{1,0,0,32'h0,   1,32'h14,  1,mem(32'h14),   32'h18};
      v[13] = '{0,0,1,32'h103, 1,32'h18,  0,32'h0,         32'h0};
      v[14] = '{0,0,0,32'h0,   1,32'h18,  0,32'h0,         32'h0};
      v[15] = '{1,0,0,32'h0,   1,32'h18,  0,32'h0,         32'h0};
      v[16] = '{1,0,0,32'h0,   1,32'h100, 1,mem(32'h100),  32'h104};
      v[17] = '{1,1,0,32'h0,   1,32'h104, 1,mem(32'h100),  32'h104};
      v[18] = '{0,1,1,32'h200, 0,32'h108, 0,32'h0,         32'h0};
      v[19] = '{1,0,0,32'h0,   1,32'h200, 1,mem(32'h200),  32'h204};
      v[20] = '{0,0,1,32'h300, 1,32'h204, 0,32'h0,         32'h0};
      v[21] = '{0,0,1,32'h402, 1,32'h204, 0,32'h0,         32'h0};
      v[22] = '{1,0,0,32'h0,   1,32'h204, 0,32'h0,         32'h0};
      v[23] = '{1,0,0,32'h0,   1,32'h400, 1,mem(32'h400),  32'h404};
      v[24] = '{0,1,0,32'h0,   1,32'h404, 1,mem(32'h400),  32'h404};
      v[25] = '{1,0,0,32'h0,   1,32'h404, 1,mem(32'h404),  32'h408};

      rst_n = 1'b0; rst2_n = 1'b0;
      stall = 1'b0; pcsrc = 1'b0; target = 32'h0;
      bus.IMemAck = 1'b0;  bus.IMemData = 32'h0;
      bus2.IMemAck = 1'b0; bus2.IMemData = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req",   {31'h0, bus.IMemReq}, 32'h0);
      check("rst_addr",  bus.IMemAddr, 32'h0);
      check("rst_valid", {31'h0, valid1}, 32'h0);
      check("rst_instr", instr1, 32'h0);
      check("rst_pc4",   pc41, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 26; i++) begin
         check($sformatf("v%0d_req", i),  {31'h0, bus.IMemReq}, {31'h0, v[i].e_req});
         check($sformatf("v%0d_addr", i), bus.IMemAddr, v[i].e_addr);
         bus.IMemAck  = v[i].ack;
         bus.IMemData = mem(bus.IMemAddr);
         stall  = v[i].stl;
         pcsrc  = v[i].src;
         target = v[i].tgt;
         @(posedge clk);
         #1;
         check($sformatf("v%0d_valid", i), {31'h0, valid1}, {31'h0, v[i].e_valid});
         check($sformatf("v%0d_instr", i), instr1, v[i].e_instr);
         if (v[i].e_valid) check($sformatf("v%0d_pc4", i), pc41, v[i].e_pc4);
      end
      bus.IMemAck = 1'b0; stall = 1'b0; pcsrc = 1'b0; target = 32'h0;

      // Wrap from PC_RESET=FFFF_FFFC, then async reset in the middle of a request.
      rst2_n = 1'b1;
      check("w_addr0", bus2.IMemAddr, 32'hFFFF_FFFC);
      check("w_req0",  {31'h0, bus2.IMemReq}, 32'h0);
      @(posedge clk); #1;
      check("w_req1",  {31'h0, bus2.IMemReq}, 32'h1);
      bus2.IMemAck  = 1'b1;
      bus2.IMemData = mem(bus2.IMemAddr);
      @(posedge clk); #1;
      check("w_instr", instr2, mem(32'hFFFF_FFFC));
      check("w_pc4",   pc42, 32'h0);
      check("w_valid", {31'h0, valid2}, 32'h1);
      check("w_addr1", bus2.IMemAddr, 32'h0);
      bus2.IMemAck = 1'b0;
      @(posedge clk); #2;
      rst2_n = 1'b0;
      #1;
      check("ar_req",   {31'h0, bus2.IMemReq}, 32'h0);
      check("ar_addr",  bus2.IMemAddr, 32'hFFFF_FFFC);
      check("ar_valid", {31'h0, valid2}, 32'h0);
      check("ar_instr", instr2, 32'h0);
      check("ar_pc4",   pc42, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
